// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and the
// MEM stage. Each access is sequenced as little-endian byte transfers, and the
// assembled word is returned with a one-cycle done pulse.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data_o,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Read latency as a counter-width constant (1..3 fits easily in 3 bits).
    localparam logic [2:0] LAT_C = 3'(RD_LAT);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              who_q, who_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic              pick_mem;
    logic [1:0]        lane;
    logic              last_rd;
    logic [31:0]       asm_word;

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        who_d       = who_q;
        n_d         = n_q;
        cyc_d       = cyc_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_addr_d  = ram_addr_q;
        if_data_d   = 32'h0;
        mem_rdata_d = 32'h0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = 8'h00;
        pick_mem    = mem_req && !(last_q == GNT_MEM && if_req);

        // Byte lane being captured this cycle (meaningful once cyc_q >= LAT_C).
        lane     = 2'(cyc_q - LAT_C);
        last_rd  = (cyc_q == (n_q - 3'd1 + LAT_C));
        asm_word = buf_q;
        case (lane)
            2'd0:    asm_word[7:0]   = ram_din;
            2'd1:    asm_word[15:8]  = ram_din;
            2'd2:    asm_word[23:16] = ram_din;
            default: asm_word[31:24] = ram_din;
        endcase

        case (state_q)
            S_IDLE: begin
                if (mem_req || if_req) begin
                    who_d   = pick_mem;
                    last_d  = pick_mem;
                    cyc_d   = 3'd0;
                    buf_d   = 32'h0;
                    wdata_d = mem_wdata[31:8];
                    if (pick_mem) begin
                        ram_addr_d = ADDR_W'(mem_addr);
                        case (mem_size)
                            2'd0:    n_d = 3'd1;
                            2'd1:    n_d = 3'd2;
                            default: n_d = 3'd4;
                        endcase
                        if (mem_we) begin
                            state_d    = S_WRITE;
                            ram_wr_d   = 1'b1;
                            ram_dout_d = mem_wdata[7:0];
                        end else begin
                            state_d = S_READ;
                        end
                    end else begin
                        ram_addr_d = ADDR_W'(if_addr);
                        n_d        = 3'd4;
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                cyc_d = cyc_q + 3'd1;
                if ((cyc_q + 3'd1) < n_q) begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
                if (cyc_q >= LAT_C) begin
                    buf_d = asm_word;
                    if (last_rd) begin
                        state_d = S_DONE;
                        if (who_q == GNT_MEM) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_word;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_word;
                        end
                    end
                end
            end
            S_WRITE: begin
                if ((cyc_q + 3'd1) < n_q) begin
                    cyc_d      = cyc_q + 3'd1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[7:0];
                    wdata_d    = {8'h00, wdata_q[23:8]};
                end else begin
                    state_d = S_DONE;
                    if (who_q == GNT_MEM) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = buf_q;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = buf_q;
                    end
                end
            end
            S_DONE: begin
                // Requests are ignored here; requesters drop or change them now.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_q      <= GNT_IF;
            who_q       <= GNT_IF;
            n_q         <= 3'd0;
            cyc_q       <= 3'd0;
            wdata_q     <= 24'h0;
            buf_q       <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            who_q       <= who_d;
            n_q         <= n_d;
            cyc_q       <= cyc_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign if_data_o   = if_data_q;
    assign if_done     = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done    = mem_done_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;

    // Stall requests drop in the done cycle so the stage releases with the data.
    assign stall_if_o  = if_req && !if_done_q;
    assign stall_mem_o = mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1/ADDR_W=32 and one
// with RD_LAT=3/ADDR_W=17, each with its own byte RAM model.
module tb_mem_arbiter;

    typedef struct {
        bit          d3;
        bit          is_mem;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        if_req1, mem_req1, if_req3, mem_req3;
    logic        mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_size;

    logic [31:0] if_data1, mem_rdata1, ram_addr1;
    logic        if_done1, mem_done1, ram_wr1, stall_if1, stall_mem1;
    logic [7:0]  dout1, din1;
    logic [31:0] if_data3, mem_rdata3;
    logic [16:0] ram_addr3;
    logic        if_done3, mem_done3, ram_wr3, stall_if3, stall_mem3;
    logic [7:0]  dout3, din3;

    logic [7:0]  mem1 [0:131071];
    logic [7:0]  mem3 [0:131071];
    logic [16:0] p1, p3a, p3b, p3c;

    int total = 0;
    int bad   = 0;
    vec_t vecs[16];

    mem_arbiter #(.ADDR_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr), .if_data_o(if_data1), .if_done(if_done1),
        .mem_req(mem_req1), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata1), .mem_done(mem_done1),
        .ram_addr_o(ram_addr1), .ram_wr_o(ram_wr1), .ram_dout_o(dout1), .ram_din(din1),
        .stall_if_o(stall_if1), .stall_mem_o(stall_mem1)
    );

    mem_arbiter #(.ADDR_W(17), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr), .if_data_o(if_data3), .if_done(if_done3),
        .mem_req(mem_req3), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata3), .mem_done(mem_done3),
        .ram_addr_o(ram_addr3), .ram_wr_o(ram_wr3), .ram_dout_o(dout3), .ram_din(din3),
        .stall_if_o(stall_if3), .stall_mem_o(stall_mem3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM models: writes on the edge, reads returned RD_LAT cycles later.
    always @(posedge clk) begin
        if (ram_wr1) mem1[ram_addr1[16:0]] <= dout1;
        if (ram_wr3) mem3[ram_addr3] <= dout3;
        p1  <= ram_addr1[16:0];
        p3a <= ram_addr3;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign din1 = mem1[p1];
    assign din3 = mem3[p3c];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Run one transaction from an IDLE-cycle negedge; returns at the next IDLE negedge.
    task automatic run_vec(input vec_t v, input string nm);
        int          n;
        int          lat_seen;
        bit          ok;
        bit          got;
        logic [31:0] ea, wd, s_addr, s_data;
        logic        s_wr, s_done, s_stall;
        logic [7:0]  s_dout;
        n = !v.is_mem ? 4 : (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        if_addr = v.addr; mem_addr = v.addr; mem_we = v.we;
        mem_size = v.size; mem_wdata = v.wdata;
        if (v.d3) begin if_req3 = !v.is_mem; mem_req3 = v.is_mem; end
        else      begin if_req1 = !v.is_mem; mem_req1 = v.is_mem; end
        ok = 1'b1; got = 1'b0; lat_seen = 0; wd = v.wdata;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (v.d3) begin
                s_addr = 32'(ram_addr3); s_wr = ram_wr3; s_dout = dout3;
                s_done  = v.is_mem ? mem_done3 : if_done3;
                s_stall = v.is_mem ? stall_mem3 : stall_if3;
                s_data  = v.is_mem ? mem_rdata3 : if_data3;
            end else begin
                s_addr = ram_addr1; s_wr = ram_wr1; s_dout = dout1;
                s_done  = v.is_mem ? mem_done1 : if_done1;
                s_stall = v.is_mem ? stall_mem1 : stall_if1;
                s_data  = v.is_mem ? mem_rdata1 : if_data1;
            end
            ea = v.addr + 32'(i - 1);
            if (v.d3) ea = ea & 32'h0001_FFFF;
            if (i <= n) begin
                if (s_addr !== ea) ok = 1'b0;
                if (v.we) begin
                    if (s_wr !== 1'b1 || s_dout !== wd[7:0]) ok = 1'b0;
                    wd = wd >> 8;
                end
            end
            if ((!v.we || i > n) && s_wr !== 1'b0) ok = 1'b0;
            if (s_done === 1'b1) begin
                got = 1'b1;
                lat_seen = i;
                if (s_stall !== 1'b0) ok = 1'b0;
                if (!v.we) chk({nm, " data"}, s_data, v.exp_data);
            end else if (s_stall !== 1'b1) begin
                ok = 1'b0;
            end
        end
        chk({nm, " latency"}, 32'(lat_seen), 32'(v.lat));
        if_req1 = 1'b0; mem_req1 = 1'b0; if_req3 = 1'b0; mem_req3 = 1'b0;
        @(negedge clk);
        if (v.d3) begin if (mem_done3 !== 1'b0 || if_done3 !== 1'b0 || ram_wr3 !== 1'b0) ok = 1'b0; end
        else      begin if (mem_done1 !== 1'b0 || if_done1 !== 1'b0 || ram_wr1 !== 1'b0) ok = 1'b0; end
        chk({nm, " sequence"}, 32'(ok), 32'd1);
    endtask

    initial begin
        bit         ok;
        int         ndone;
        int         tstamp[4];
        logic [3:0] ord;
        bit         re_if, re_mem;

        //            d3 mem we size addr           wdata          exp_data       lat
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'h0010_0513, 32'h0,          5};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h0010_0513, 6};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_2000, 32'hAABB_CCDD, 32'h0,          3};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_2002, 32'h1234_5677, 32'h0,          2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_0099, 32'h0,          2};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0,          32'h9977_CCDD, 6};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_2001, 32'h0,          32'h0000_77CC, 4};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_2003, 32'h0,          32'h0000_0099, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,          32'h0010_0513, 6};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0007, 32'h0000_0080, 32'h0,          2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0007, 32'h0,          32'h0000_0080, 5};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0001_FFFE, 32'hD4C3_B2A1, 32'h0,          5};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0001_FFFE, 32'h0,          32'hD4C3_B2A1, 8};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0400, 32'hEEEE_EEEE, 32'h0,          5};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0,          32'hEEEE_0304, 6};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h0010_0513, 6};

        rst = 1'b0;
        if_req1 = 1'b0; mem_req1 = 1'b0; if_req3 = 1'b0; mem_req3 = 1'b0;
        mem_we = 1'b0; if_addr = 32'h0; mem_addr = 32'h0; mem_size = 2'd0; mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset flags", 32'({if_done1, mem_done1, ram_wr1, stall_if1, stall_mem1}), 32'h0);
        chk("reset if_data", if_data1, 32'h0);
        chk("reset mem_rdata", mem_rdata1, 32'h0);
        chk("reset ram_addr", ram_addr1, 32'h0);
        chk("reset ram_dout", 32'(dout1), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset while a word store is between its second and third byte.
        mem_addr = 32'h400; mem_we = 1'b1; mem_size = 2'd2; mem_wdata = 32'h0102_0304;
        mem_req1 = 1'b1;
        @(negedge clk);
        chk("rstw byte0", {ram_addr1[23:0], dout1}, {24'h000400, 8'h04});
        chk("rstw wr0", 32'(ram_wr1), 32'd1);
        @(negedge clk);
        chk("rstw byte1", {ram_addr1[23:0], dout1}, {24'h000401, 8'h03});
        rst = 1'b0; mem_req1 = 1'b0;
        @(negedge clk);
        chk("rstw flags", 32'({ram_wr1, mem_done1, if_done1}), 32'h0);
        chk("rstw outputs", ram_addr1 | 32'(dout1) | mem_rdata1 | if_data1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_done1 !== 1'b0 || ram_wr1 !== 1'b0) ok = 1'b0;
        end
        chk("rstw quiet", 32'(ok), 32'd1);
        run_vec(vecs[14], "vec14");
        run_vec(vecs[15], "vec15");

        // Contention: both requests held, each re-raised in the IDLE cycle after its done.
        mem_addr = 32'h2000; mem_we = 1'b0; mem_size = 2'd2; if_addr = 32'h100;
        if_req1 = 1'b1; mem_req1 = 1'b1;
        ndone = 0; ord = 4'h0; re_if = 1'b0; re_mem = 1'b0;
        for (int i = 0; i < 4; i++) tstamp[i] = 0;
        for (int c = 1; c <= 60 && ndone < 4; c++) begin
            @(negedge clk);
            if (re_if)  if_req1 = 1'b1;
            if (re_mem) mem_req1 = 1'b1;
            re_if = 1'b0; re_mem = 1'b0;
            if (mem_done1 === 1'b1) begin
                chk("fair mem data", mem_rdata1, 32'h9977_CCDD);
                ord = {ord[2:0], 1'b1}; tstamp[ndone] = c; ndone++;
                mem_req1 = 1'b0; re_mem = 1'b1;
            end else if (if_done1 === 1'b1) begin
                chk("fair if data", if_data1, 32'h0010_0513);
                ord = {ord[2:0], 1'b0}; tstamp[ndone] = c; ndone++;
                if_req1 = 1'b0; re_if = 1'b1;
            end
        end
        chk("fair order", 32'(ord), 32'b1010);
        chk("fair done0", 32'(tstamp[0]), 32'd6);
        chk("fair done1", 32'(tstamp[1]), 32'd13);
        chk("fair done2", 32'(tstamp[2]), 32'd20);
        chk("fair done3", 32'(tstamp[3]), 32'd27);
        if_req1 = 1'b0; mem_req1 = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM port between the instruction-fetch stage and the MEM stage of the RISC-V pipeline. It sequences each multi-byte access as consecutive little-endian byte transfers. It returns the assembled word with a one-cycle done pulse, and raises per-requester stall requests to ctrl.v while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32: width of ram_addr_o; byte addresses are truncated to the low ADDR_W bits.
- RD_LAT, 1: RAM read latency in cycles, 1..3. An address driven in cycle c returns its byte on ram_din in cycle c+RD_LAT.

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- if_req  in  1  instruction fetch request, held until if_done.
- if_addr  in  32  fetch byte address; always a 4-byte read.
- if_data_o  out  32  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for the fetch.
- mem_req  in  1  load/store request, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  load/store byte address.
- mem_size  in  2  0 = byte, 1 = half, 2 or 3 = word.
- mem_wdata  in  32  store data, least-significant byte first.
- mem_rdata_o  out  32  raw load data, zero-filled above the size and not sign-extended; valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse for the load/store.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write strobe.
- ram_dout_o  out  8  RAM write byte.
- ram_din  in  8  RAM read byte.
- stall_if_o  out  1  to ctrl.v: if_req && !if_done (combinational).
- stall_mem_o  out  1  to ctrl.v: mem_req && !mem_done (combinational).

## Operation
- State machine states: IDLE, READ, WRITE, DONE. All outputs except the stall signals are registered.
- IDLE, grant rule:
  - mem_req wins, unless last_grant==MEM and if_req=1; in that case if wins.
  - last_grant updates on every grant and resets to IF.
- IDLE, on a grant:
  - Latch the requester id, address, n (1, 2 or 4), we and wdata.
  - Clear the byte counter.
  - Go to READ (load or fetch) or WRITE (store).
- Nothing is latched in IDLE when both requests are low.
- READ:
  - Issue address addr+k for k = 0..n-1, one per cycle.
  - Capture ram_din into byte lane k in the cycle addr+k+RD_LAT is valid.
  - Unused lanes are 0.
  - After the last capture, go to DONE.
- WRITE:
  - Drive ram_wr_o=1, ram_addr_o=addr+k and ram_dout_o=wdata[8k+7:8k] for k = 0..n-1.
  - Go to DONE after the last byte.
- DONE:
  - Pulse the granted requester's done for one cycle.
  - Drive the data output for that requester.
  - Go to IDLE.
  - req inputs are ignored in this cycle; the requester drops or changes its request here.
- Address arithmetic is mod 2^ADDR_W. Misaligned addresses are legal and wrap silently.
- Outside WRITE, ram_wr_o=0, ram_dout_o=0 and ram_addr_o holds its last value.
- No preemption: a granted access always completes unless reset occurs.

## Timing
- Reset (rst=0 at a rising edge), effective from the next cycle:
  - State IDLE.
  - if_done=mem_done=0, if_data_o=mem_rdata_o=0.
  - ram_addr_o=0, ram_wr_o=0, ram_dout_o=0.
  - last_grant=IF.
- Reset mid-access abandons the transfer: no done pulse, and ram_wr_o is low from the next cycle.
- Let the grant occur in IDLE cycle T:
  - Byte k address appears in cycle T+1+k.
  - Read done is in cycle T+n+RD_LAT+1. A word fetch with RD_LAT=1 completes in T+6.
  - Write done is in cycle T+n+1. A word store completes in T+5.
- Earliest next grant is cycle done+1, because IDLE follows DONE.
- Stall signals:
  - stall_*_o falls in the done cycle, so ctrl.v releases that stage on the same edge the data is captured.
  - The losing requester's stall stays high throughout.

## Test plan
- Fetch only: if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00, RD_LAT=1. Required: ram_addr_o=0x100..0x103 in T+1..T+4, if_done in T+6 with if_data_o=0x00100513, stall_if_o low only in T+6.
- Byte/half store: mem_we=1, size=1, addr=0x2000, wdata=0xAABBCCDD. Required: exactly two write cycles (0x2000←0xDD, 0x2001←0xCC), mem_done in T+3, ram_wr_o low afterwards.
- Contention and fairness: if_req and mem_req asserted together in cycle 0 and held, each re-asserted immediately after its done. Required: grant order MEM, IF, MEM, IF, with one DONE cycle and one IDLE cycle between accesses.
- Byte load, RD_LAT=3: size=0, addr=0x7, ram_din=0x80. Required: mem_rdata_o=0x00000080 (no sign extension), mem_done in T+5.
- Wrap-around: ADDR_W=17, word fetch at 0x1FFFE. Required: addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset during WRITE after 2 of 4 bytes: required no further ram_wr_o, no mem_done, all outputs 0, and a fresh if_req granted normally after rst returns high.
